// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and lane helpers for mem_access_ctrl
package mem_access_pkg;

    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
    localparam logic [31:0] WORD_MASK = 32'hffff_ffff;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

    // Reserved size 11 behaves as a word, so anything >= SZ_WORD is a word access
    function automatic logic is_word(input logic [1:0] size);
        return size >= SZ_WORD;
    endfunction

    // Bit offset of the addressed lane; misaligned low address bits are dropped
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? {off, 3'b000} : size == SZ_HALF ? {off[1], 4'b0000} : 5'd0;
    endfunction

    // Unshifted mask covering the bits of one access of the given size
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        return size == SZ_BYTE ? BYTE_MASK : size == SZ_HALF ? HALF_MASK : WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: little-endian load extract/extend and sub-word store merge
module mem_lane_fmt (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);
    import mem_access_pkg::*;

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Right-justify and extend the addressed lane; splice store data into the old word
    always_comb begin
        sh     = lane_shift(size, off);
        mask   = lane_mask(size) << sh;
        lane_b = rword[{off, 3'b000} +: 8];
        lane_h = rword[{off[1], 4'b0000} +: 16];
        ldata  = size == SZ_BYTE ? {{24{sign_ext & lane_b[7]}}, lane_b}
               : size == SZ_HALF ? {{16{sign_ext & lane_h[15]}}, lane_h}
               : rword;
        mdata  = (rword & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: req/done load/store sequencer for a word-only data memory.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module mem_access_ctrl #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          misalign,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    input  logic [DW-1:0] dm_dout
);
    import mem_access_pkg::*;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [1:0]    off_q, off_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [DW-1:0] dm_din_q, dm_din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          mis_req;
    logic [DW-1:0] ldata, mdata;
    logic          unused_addr_hi;

    // Address bits above the memory window wrap and are deliberately ignored
    assign unused_addr_hi = ^addr[DW-1:AW+2];

`ifdef MISALIGN_TRAP_EN
    assign mis_req = (size == SZ_HALF && addr[0]) || (is_word(size) && addr[1:0] != 2'b00);
`else
    assign mis_req = 1'b0;
`endif

    mem_lane_fmt u_fmt (
        .size     (size_q),
        .off      (off_q),
        .sign_ext (sext_q),
        .rword    (dm_dout),
        .wdata    (wdata_q),
        .ldata    (ldata),
        .mdata    (mdata)
    );

    // Next-state and datapath: IDLE accepts, READ samples memory, WRITE commits, DONE reports
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sext_d    = sext_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        rdata_d   = rdata_q;
        mis_d     = 1'b0;
        case (state_q)
            ST_IDLE: if (req) begin
                we_d      = we;
                size_d    = size;
                sext_d    = sign_ext;
                off_d     = addr[1:0];
                wdata_d   = wdata;
                dm_addr_d = addr[AW+1:2];
                mis_d     = mis_req;
                dm_din_d  = (we && !mis_req && is_word(size)) ? wdata : dm_din_q;
                state_d   = mis_req ? ST_DONE : (we && is_word(size)) ? ST_WRITE : ST_READ;
            end
            ST_READ: begin
                dm_din_d = we_q ? mdata : dm_din_q;
                rdata_d  = we_q ? rdata_q : ldata;
                state_d  = we_q ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            sext_q    <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= '0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
            rdata_q   <= rdata_d;
            mis_q     <= mis_d;
        end
    end

    assign busy     = state_q != ST_IDLE;
    assign done     = state_q == ST_DONE;
    assign dm_we    = state_q == ST_WRITE;
    assign misalign = mis_q;
    assign rdata    = rdata_q;
    assign dm_addr  = dm_addr_q;
    assign dm_din   = dm_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a behavioural word memory
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, misalign, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;
    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    int lat, wes;
    logic mis;
    logic [5:0] busy_pat, done_pat;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .dm_dout  (dm_dout)
    );

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: lat = negedges after the accepting edge until done (10 = timeout)
    task automatic txn(input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d,
                       output int l, output int wc, output logic m);
        @(negedge clk);
        req = 1'b1; we = w; size = s; sign_ext = se; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        l = 1; wc = 0;
        while (!done && l < 10) begin
            wc += int'(dm_we);
            @(negedge clk);
            l++;
        end
        wc += int'(dm_we);
        m = misalign;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", 32'(dm_addr), 0);
        chk("rst_din", dm_din, 0);
        rst_n = 1'b1;

        // 1: word store then word load
        txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, wes, mis);
        chk("sw_lat", lat, 2);
        chk("sw_we_cycles", wes, 1);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_done_pulse", done, 0);
        chk("sw_busy_after", busy, 0);
        txn(0, 2'b10, 0, 32'h10, 0, lat, wes, mis);
        chk("lw_lat", lat, 2);
        chk("lw_we_cycles", wes, 0);
        chk("lw_rdata", rdata, 32'hDEADBEEF);

        // 2: byte store read-modify-write
        mem[4] = 32'h11223344;
        txn(1, 2'b00, 0, 32'h11, 32'h000000AA, lat, wes, mis);
        chk("sb_lat", lat, 3);
        chk("sb_we_cycles", wes, 1);
        chk("sb_mem", mem[4], 32'h1122AA44);

        // 3: sub-word loads and half store
        mem[5] = 32'h80FF7F01;
        txn(0, 2'b00, 1, 32'h15, 0, lat, wes, mis);
        chk("lb15_rdata", rdata, 32'h0000007F);
        chk("lb15_addr", 32'(dm_addr), 5);
        txn(0, 2'b00, 1, 32'h16, 0, lat, wes, mis);
        chk("lb16_rdata", rdata, 32'hFFFFFFFF);
        txn(0, 2'b01, 0, 32'h16, 0, lat, wes, mis);
        chk("lhu16_rdata", rdata, 32'h000080FF);
        txn(0, 2'b01, 1, 32'h16, 0, lat, wes, mis);
        chk("lh16_rdata", rdata, 32'hFFFF80FF);
        txn(0, 2'b00, 0, 32'h17, 0, lat, wes, mis);
        chk("lbu17_rdata", rdata, 32'h00000080);
        txn(1, 2'b01, 0, 32'h16, 32'hBEEF1234, lat, wes, mis);
        chk("sh_lat", lat, 3);
        chk("sh_mem", mem[5], 32'h12347F01);
        txn(0, 2'b11, 1, 32'h14, 0, lat, wes, mis);
        chk("lw_rsvd_rdata", rdata, 32'h12347F01);
        txn(0, 2'b10, 0, 32'h10000010, 0, lat, wes, mis);
        chk("lw_wrap_rdata", rdata, 32'h1122AA44);
        chk("lw_wrap_addr", 32'(dm_addr), 4);

        // 4: req held high across two loads
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h14;
        busy_pat = '0; done_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_pat = {busy_pat[4:0], busy};
            done_pat = {done_pat[4:0], done};
        end
        req = 1'b0;
        chk("held_busy_pat", 32'(busy_pat), 32'(6'b110110));
        chk("held_done_pat", 32'(done_pat), 32'(6'b010010));
        chk("held_rdata", rdata, 32'h12347F01);

        // 5: reset during WRITE aborts the store
        mem[8] = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        chk("abort_we_before", dm_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", dm_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_addr", 32'(dm_addr), 0);
        chk("abort_din", dm_din, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        chk("abort_mem", mem[8], 0);
        rst_n = 1'b1;

        // 6: misaligned accesses
        txn(0, 2'b10, 0, 32'h14, 0, lat, wes, mis);
        chk("pre_mis_rdata", rdata, 32'h12347F01);
        txn(0, 2'b10, 0, 32'h13, 0, lat, wes, mis);
        chk("mis_lw_we", wes, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lw_lat", lat, 1);
        chk("mis_lw_flag", mis, 1);
        chk("mis_lw_rdata", rdata, 32'h12347F01);
`else
        chk("mis_lw_lat", lat, 2);
        chk("mis_lw_flag", mis, 0);
        chk("mis_lw_rdata", rdata, 32'h1122AA44);
`endif
        txn(0, 2'b01, 0, 32'h11, 0, lat, wes, mis);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lh_flag", mis, 1);
        chk("mis_lh_rdata", rdata, 32'h12347F01);
`else
        chk("mis_lh_flag", mis, 0);
        chk("mis_lh_rdata", rdata, 32'h0000AA44);
`endif
        @(negedge clk);
        chk("end_mis_clear", misalign, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
